spi_master_tx: RTL

- SPI master transmitter (mode 0, MSB first) that drives SCLK/MOSI/CS_N toward an external SPI slave; the counterpart of the design's SPI byte receiver.
- Accepts bytes from upstream logic over a valid/ready handshake and serialises them.
- Samples MISO in parallel and returns one received byte per transmitted byte.
- Supports back-to-back bursts with CS_N held low, plus programmable CS setup, hold and idle times.

---
 rtl/spi_master_tx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter, MSB first. It takes bytes over a valid/ready
// handshake, samples MISO on each SCLK rise, and returns one received byte per
// transmitted byte. Back-to-back bytes keep CS_N low, and the CS setup, hold
// and idle times are programmable.
module spi_master_tx #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       byte_valid_in,
  input  logic [7:0] byte_data_in,
  output logic       byte_ready_out,
  input  logic       spi_miso_in,
  output logic       spi_sclk_out,
  output logic       spi_mosi_out,
  output logic       spi_cs_n_out,
  output logic       rx_valid_out,
  output logic [7:0] rx_data_out,
  output logic       busy_out
);

  localparam int unsigned MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned MAX_CD = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int unsigned MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CW-1:0] LAST_DIV   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAST_SETUP = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] LAST_HOLD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] LAST_IDLE  = CW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_tx_sh;
  logic [7:0]    w_tx_sh_nxt;
  logic [7:0]    r_rx_sh;
  logic [7:0]    w_rx_sh_nxt;
  logic [7:0]    r_rx_data;
  logic [7:0]    w_rx_data_nxt;
  logic          r_rx_valid;
  logic          w_rx_valid_nxt;
  logic          r_ready;
  logic          w_ready_nxt;
  logic          r_sclk;
  logic          r_cs_n;
  logic          r_busy;
  logic          w_accept;

  // A byte is taken whenever upstream offers one while ready is shown.
  assign w_accept = byte_valid_in & r_ready;

  // Next-state, counters, shift registers and registered-output values.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + CW'(1);
    w_bit_nxt      = r_bit;
    w_tx_sh_nxt    = r_tx_sh;
    w_rx_sh_nxt    = r_rx_sh;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_state_nxt = S_SETUP;
          w_tx_sh_nxt = byte_data_in;
        end
      end
      S_SETUP: begin
        if (r_cnt == LAST_SETUP) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
          w_rx_sh_nxt = {r_rx_sh[6:0], spi_miso_in};
        end
      end
      S_HIGH: begin
        if (r_cnt == LAST_DIV) begin
          w_cnt_nxt = '0;
          // The 3-bit count wraps 7 -> 0 here, so a burst reload or a new
          // frame always starts from bit count 0 without the handshake
          // touching it.
          w_bit_nxt = r_bit + 3'd1;
          if (r_bit != 3'd7) begin
            w_state_nxt = S_LOW;
            w_tx_sh_nxt = {r_tx_sh[6:0], 1'b0};
          end else begin
            w_rx_valid_nxt = 1'b1;
            w_rx_data_nxt  = r_rx_sh;
            if (w_accept) begin
              w_state_nxt = S_LOW;
              w_tx_sh_nxt = byte_data_in;
            end else begin
              w_state_nxt = S_HOLD;
            end
          end
        end
      end
      S_LOW: begin
        if (r_cnt == LAST_DIV) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
          w_rx_sh_nxt = {r_rx_sh[6:0], spi_miso_in};
        end
      end
      S_HOLD: begin
        if (r_cnt == LAST_HOLD) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end
      end
      S_GAP: begin
        if (r_cnt == LAST_IDLE) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // Ready is registered, so it is derived from where the FSM is heading:
    // always in IDLE, and in the last HIGH cycle of the final bit (burst slot).
    w_ready_nxt = (w_state_nxt == S_IDLE) ||
                  ((w_state_nxt == S_HIGH) && (w_bit_nxt == 3'd7) &&
                   (w_cnt_nxt == LAST_DIV));
  end

  // State and registered outputs; synchronous reset drops everything to idle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_ready    <= 1'b0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_tx_sh    <= w_tx_sh_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_ready    <= w_ready_nxt;
      r_sclk     <= (w_state_nxt == S_HIGH);
      r_cs_n     <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign byte_ready_out = r_ready;
  assign spi_sclk_out   = r_sclk;
  assign spi_mosi_out   = r_tx_sh[7];
  assign spi_cs_n_out   = r_cs_n;
  assign rx_valid_out   = r_rx_valid;
  assign rx_data_out    = r_rx_data;
  assign busy_out       = r_busy;

endmodule
